// File: rtl/text_line_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_text_pkg
//  Description : Shared constants for the LCD text path: FSM state codes,
//                ASCII constants and the LCD column geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_text_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // ASCII constants
    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [7:0] QMARK     = 8'h3F;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    // LCD geometry; columns wrap modulo LCD_COLS
    localparam int LCD_COLS = 16;
    localparam int COL_W    = $clog2(LCD_COLS);

endpackage : lcd_text_pkg
`default_nettype wire

// File: rtl/text_line_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_line_writer_if
//  Description : Character write port towards the LCD controller
//                (valid/ready handshake carrying one character + address).
//  Revision    : 1.0 - initial release
// ============================================================================
interface text_line_writer_if;
    import lcd_text_pkg::*;

    logic             char_valid;
    logic             char_ready;
    logic [7:0]       char_data;
    logic             char_row;
    logic [COL_W-1:0] char_col;

    modport master (
        output char_valid,
        output char_data,
        output char_row,
        output char_col,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_data,
        input  char_row,
        input  char_col,
        output char_ready
    );

endinterface : text_line_writer_if
`default_nettype wire

// File: rtl/char_sanitize.sv
`default_nettype none
// ============================================================================
//  Module      : char_sanitize
//  Description : Replaces non-printable bytes (outside 0x20..0x7E) with '?'
//                so the LCD never receives control codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module char_sanitize
    import lcd_text_pkg::*;
(
    input  wire logic [7:0] i_byte,
    output logic      [7:0] o_byte
);

    // Pass printable characters, substitute everything else
    always_comb begin
        o_byte = i_byte;
        if ((i_byte < PRINT_MIN) || (i_byte > PRINT_MAX)) begin
            o_byte = QMARK;
        end
    end

endmodule : char_sanitize
`default_nettype wire

// File: rtl/text_line_writer.sv
`default_nettype none
// ============================================================================
//  Module      : text_line_writer
//  Description : Snapshots NCHAR ASCII characters on request and streams them
//                leftmost first to the LCD write port, one per handshake.
//                Requests arriving while busy are held in a one-deep pending
//                buffer (latest request wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module text_line_writer
    import lcd_text_pkg::*;
#(
    parameter int NCHAR    = 5,
    parameter int ROW      = 0,
    parameter int COL_BASE = 0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               update,
    input  wire logic [8*NCHAR-1:0] text_in,
    text_line_writer_if.master      lcd,
    output logic                    busy,
    output logic                    done
);

    localparam logic [3:0]       c_last     = 4'(NCHAR - 1);
    localparam logic [COL_W-1:0] c_col_base = COL_W'(COL_BASE);

    logic [1:0]         r_state,   w_state_nxt;
    logic [8*NCHAR-1:0] r_snap,    w_snap_nxt;
    logic [8*NCHAR-1:0] r_pend,    w_pend_nxt;
    logic               r_pending, w_pending_nxt;
    logic [3:0]         r_idx,     w_idx_nxt;
    logic               r_valid,   w_valid_nxt;
    logic [7:0]         r_data,    w_data_nxt;
    logic [COL_W-1:0]   r_col,     w_col_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;

    logic [8*NCHAR-1:0] w_src;
    logic [3:0]         w_src_idx;
    logic [8*NCHAR-1:0] w_shifted;
    logic [7:0]         w_raw;
    logic [7:0]         w_clean;

    // Pick the text and character index for the character shown next:
    // a fresh load starts at index 0, otherwise the following snapshot char
    always_comb begin
        w_src     = r_snap;
        w_src_idx = r_idx + 4'd1;
        if (r_state == ST_IDLE) begin
            w_src     = text_in;
            w_src_idx = 4'd0;
        end else if (r_state == ST_FINISH) begin
            w_src     = update ? text_in : r_pend;
            w_src_idx = 4'd0;
        end
    end

    // Leftmost character sits in the MSBs, so shift it up to the top byte
    assign w_shifted = w_src << {w_src_idx, 3'b000};
    assign w_raw     = w_shifted[8*NCHAR-1 -: 8];

    char_sanitize u_sanitize (
        .i_byte (w_raw),
        .o_byte (w_clean)
    );

    // Next-state and next-output logic for the transfer FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_snap_nxt    = r_snap;
        w_pend_nxt    = r_pend;
        w_pending_nxt = r_pending;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_data_nxt    = r_data;
        w_col_nxt     = r_col;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (update) begin
                    w_snap_nxt  = w_src;
                    w_idx_nxt   = 4'd0;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_clean;
                    w_col_nxt   = c_col_base;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (update) begin
                    w_pend_nxt    = text_in;
                    w_pending_nxt = 1'b1;
                end
                if (r_valid && lcd.char_ready) begin
                    if (r_idx == c_last) begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_idx_nxt  = w_src_idx;
                        w_data_nxt = w_clean;
                        w_col_nxt  = c_col_base + COL_W'(w_src_idx);
                    end
                end
            end
            ST_FINISH: begin
                // An update landing in this cycle is the newest request
                if (update || r_pending) begin
                    w_snap_nxt    = w_src;
                    w_pending_nxt = 1'b0;
                    w_idx_nxt     = 4'd0;
                    w_valid_nxt   = 1'b1;
                    w_data_nxt    = w_clean;
                    w_col_nxt     = c_col_base;
                    w_state_nxt   = ST_SEND;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt   = 1'b0;
                w_busy_nxt    = 1'b0;
                w_pending_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and drops pending
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_pend    <= '0;
            r_pending <= 1'b0;
            r_idx     <= 4'd0;
            r_valid   <= 1'b0;
            r_data    <= SPACE;
            r_col     <= c_col_base;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_snap    <= w_snap_nxt;
            r_pend    <= w_pend_nxt;
            r_pending <= w_pending_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_col     <= w_col_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign lcd.char_valid = r_valid;
    assign lcd.char_data  = r_data;
    assign lcd.char_col   = r_col;
    assign lcd.char_row   = 1'(ROW);
    assign busy           = r_busy;
    assign done           = r_done;

endmodule : text_line_writer
`default_nettype wire
